// File: rtl/framebuffer_writer.sv
`timescale 1ns/1ps
// Double-buffered framebuffer writer: clips rasterizer pixels into the hidden buffer, clears it and swaps buffers.
// Pixel writes land 2 cycles after acceptance at 1/cycle; ready drops whenever a clear or swap is in progress.

module framebuffer_writer #(
    parameter int  H_RES       = 320,
    parameter int  V_RES       = 180,
    parameter int  COORD_WIDTH = 32,
    parameter int  COLOR_WIDTH = 8,
    localparam int FB_SIZE     = H_RES * V_RES,
    localparam int ADDR_WIDTH  = $clog2(2 * FB_SIZE)
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic signed [COORD_WIDTH-1:0] x_in,
    input  logic signed [COORD_WIDTH-1:0] y_in,
    input  logic                          pixel_valid,
    input  logic        [COLOR_WIDTH-1:0] color_in,
    input  logic                          raster_done,
    input  logic                          clear_start,
    input  logic        [COLOR_WIDTH-1:0] clear_color,
    output logic                          ready,
    output logic                          busy,
    output logic        [ADDR_WIDTH-1:0]  fb_addr,
    output logic        [COLOR_WIDTH-1:0] fb_data,
    output logic                          fb_we,
    output logic                          display_sel,
    output logic                          frame_done,
    output logic                          clear_done,
    output logic        [15:0]            clip_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2,
        SWAP  = 2'd3
    } state_t;

    localparam logic        [ADDR_WIDTH-1:0]  FB_SIZE_A = ADDR_WIDTH'(FB_SIZE);
    localparam logic        [ADDR_WIDTH-1:0]  H_RES_A   = ADDR_WIDTH'(H_RES);
    localparam logic signed [COORD_WIDTH-1:0] H_LIM     = COORD_WIDTH'(H_RES);
    localparam logic signed [COORD_WIDTH-1:0] V_LIM     = COORD_WIDTH'(V_RES);

    state_t                 state;
    logic                   pending;
    logic [ADDR_WIDTH-1:0]  clr_idx;
    logic [COLOR_WIDTH-1:0] clr_color;

    logic                   s1_vld;
    logic                   s1_clip;
    logic [ADDR_WIDTH-1:0]  s1_x;
    logic [ADDR_WIDTH-1:0]  s1_yoff;
    logic [COLOR_WIDTH-1:0] s1_color;
    logic                   s2_vld;

    logic                   accept;
    logic                   pipe_empty;
    logic [ADDR_WIDTH-1:0]  draw_base;

    assign accept     = pixel_valid && ready;
    assign pipe_empty = !s1_vld && !s2_vld;
    assign draw_base  = display_sel ? '0 : FB_SIZE_A;
    assign busy       = (state != IDLE);

    // Control FSM; ready is registered from the state being entered so it always matches the current state.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state       <= IDLE;
            ready       <= 1'b0;
            display_sel <= 1'b0;
            frame_done  <= 1'b0;
            clear_done  <= 1'b0;
            pending     <= 1'b0;
            clr_idx     <= '0;
            clr_color   <= '0;
        end else begin
            frame_done <= 1'b0;
            clear_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_start) begin
                        state     <= DRAIN;
                        ready     <= 1'b0;
                        clr_color <= clear_color;
                        if (raster_done) begin
                            pending <= 1'b1;
                        end
                    end else if (raster_done || pending) begin
                        state   <= SWAP;
                        ready   <= 1'b0;
                        pending <= 1'b0;
                    end else begin
                        ready <= 1'b1;
                    end
                end
                DRAIN: begin
                    ready <= 1'b0;
                    if (raster_done) begin
                        pending <= 1'b1;
                    end
                    if (pipe_empty) begin
                        state   <= CLEAR;
                        clr_idx <= '0;
                    end
                end
                CLEAR: begin
                    if (raster_done) begin
                        pending <= 1'b1;
                    end
                    // One extra cycle after the last write so clear_done trails it and ready stays low throughout.
                    if (clr_idx == FB_SIZE_A) begin
                        state      <= IDLE;
                        ready      <= 1'b1;
                        clear_done <= 1'b1;
                    end else begin
                        ready   <= 1'b0;
                        clr_idx <= clr_idx + ADDR_WIDTH'(1);
                    end
                end
                SWAP: begin
                    if (pipe_empty) begin
                        state       <= IDLE;
                        ready       <= 1'b1;
                        display_sel <= !display_sel;
                        frame_done  <= 1'b1;
                    end else begin
                        ready <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // Pixel stage 1: capture coordinates, classify off-screen pixels, precompute the row offset.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            s1_vld   <= 1'b0;
            s1_clip  <= 1'b0;
            s1_x     <= '0;
            s1_yoff  <= '0;
            s1_color <= '0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1_clip  <= (x_in < 0) || (x_in >= H_LIM) || (y_in < 0) || (y_in >= V_LIM);
                s1_x     <= ADDR_WIDTH'(unsigned'(x_in));
                s1_yoff  <= ADDR_WIDTH'(unsigned'(y_in)) * H_RES_A;
                s1_color <= color_in;
            end
        end
    end

    // Stage 2 and the clear sweep share the write port; the FSM guarantees they never overlap.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            s2_vld     <= 1'b0;
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_data    <= '0;
            clip_count <= '0;
        end else begin
            s2_vld <= s1_vld;
            if (state == CLEAR && clr_idx != FB_SIZE_A) begin
                fb_we   <= 1'b1;
                fb_addr <= draw_base + clr_idx;
                fb_data <= clr_color;
            end else begin
                fb_we <= s1_vld && !s1_clip;
                if (s1_vld && !s1_clip) begin
                    fb_addr <= draw_base + s1_yoff + s1_x;
                    fb_data <= s1_color;
                end
            end
            if (s1_vld && s1_clip && clip_count != 16'hFFFF) begin
                clip_count <= clip_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_framebuffer_writer.sv
`timescale 1ns/1ps
// Directed bench: a default-size writer for pixel, clip, clear, swap and reset cases; a tiny one for coincident events.

module tb_framebuffer_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_big;
    logic               rst_small;
    logic signed [31:0] x;
    logic signed [31:0] y;
    logic               pixel_valid;
    logic [7:0]         color;
    logic               raster_done;
    logic               clear_start;
    logic [7:0]         clear_color;

    logic        ready, busy, fb_we, display_sel, frame_done, clear_done;
    logic [16:0] fb_addr;
    logic [7:0]  fb_data;
    logic [15:0] clip_count;

    logic        s_ready, s_busy, s_fb_we, s_display_sel, s_frame_done, s_clear_done;
    logic [5:0]  s_fb_addr;
    logic [7:0]  s_fb_data;
    logic [15:0] s_clip_count;

    framebuffer_writer dut (
        .clk_in(clk), .rst_in(rst_big), .x_in(x), .y_in(y), .pixel_valid(pixel_valid),
        .color_in(color), .raster_done(raster_done), .clear_start(clear_start),
        .clear_color(clear_color), .ready(ready), .busy(busy), .fb_addr(fb_addr),
        .fb_data(fb_data), .fb_we(fb_we), .display_sel(display_sel), .frame_done(frame_done),
        .clear_done(clear_done), .clip_count(clip_count)
    );

    framebuffer_writer #(.H_RES(8), .V_RES(4), .COORD_WIDTH(32), .COLOR_WIDTH(8)) dut_small (
        .clk_in(clk), .rst_in(rst_small), .x_in(x), .y_in(y), .pixel_valid(pixel_valid),
        .color_in(color), .raster_done(raster_done), .clear_start(clear_start),
        .clear_color(clear_color), .ready(s_ready), .busy(s_busy), .fb_addr(s_fb_addr),
        .fb_data(s_fb_data), .fb_we(s_fb_we), .display_sel(s_display_sel),
        .frame_done(s_frame_done), .clear_done(s_clear_done), .clip_count(s_clip_count)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic signed [31:0] vx;
        logic signed [31:0] vy;
        logic [7:0]         vc;
        logic               we;
        logic [16:0]        addr;
    } pix_vec_t;

    localparam int NVEC = 7;
    pix_vec_t vecs [NVEC];

    initial begin
        int phase, nclr, ncd, nfd, seq_bad, nw, bad, cyc, cd_cycle, fd_cycle, extra;
        logic pix_ok, fd_seen, rd_sent, fd_sel, hit;

        vecs[0] = '{vx: 5,   vy: 2,   vc: 8'hA5, we: 1'b1, addr: 17'd58245};
        vecs[1] = '{vx: -1,  vy: 0,   vc: 8'h11, we: 1'b0, addr: 17'd0};
        vecs[2] = '{vx: 320, vy: 0,   vc: 8'h22, we: 1'b0, addr: 17'd0};
        vecs[3] = '{vx: 0,   vy: 180, vc: 8'h33, we: 1'b0, addr: 17'd0};
        vecs[4] = '{vx: 319, vy: 179, vc: 8'h44, we: 1'b1, addr: 17'd115199};
        vecs[5] = '{vx: 100, vy: 50,  vc: 8'hC3, we: 1'b1, addr: 17'd73700};
        vecs[6] = '{vx: 0,   vy: 0,   vc: 8'h5A, we: 1'b1, addr: 17'd57600};

        rst_big = 1'b0; rst_small = 1'b0;
        x = 0; y = 0; pixel_valid = 1'b0; color = 8'h00;
        raster_done = 1'b0; clear_start = 1'b0; clear_color = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", ready, 0);
        check("rst_busy", busy, 0);
        check("rst_fb_we", fb_we, 0);
        check("rst_fb_addr", fb_addr, 0);
        check("rst_display_sel", display_sel, 0);
        check("rst_clip_count", clip_count, 0);

        // Coincident pixel + clear + raster_done on the 8x4 instance (draw base 32).
        @(negedge clk) rst_small = 1'b1;
        @(posedge clk); #1;
        check("small_ready_after_reset", s_ready, 1);
        x = 2; y = 1; color = 8'h5C; pixel_valid = 1'b1;
        clear_start = 1'b1; clear_color = 8'hC7; raster_done = 1'b1;
        @(posedge clk); #1;
        pixel_valid = 1'b0; clear_start = 1'b0; raster_done = 1'b0;
        phase = 0; nclr = 0; ncd = 0; nfd = 0; seq_bad = 0; pix_ok = 1'b0; fd_sel = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (s_fb_we) begin
                if (phase == 0) begin
                    if (s_fb_addr == 6'd42 && s_fb_data == 8'h5C) pix_ok = 1'b1;
                    else seq_bad++;
                    phase = 1;
                end else if (phase == 1) begin
                    if (int'(s_fb_addr) != 32 + nclr || s_fb_data != 8'hC7) seq_bad++;
                    nclr++;
                end else begin
                    seq_bad++;
                end
            end
            if (s_clear_done) begin
                ncd++;
                if (phase != 1 || nclr != 32) seq_bad++;
                phase = 2;
            end
            if (s_frame_done) begin
                nfd++;
                if (phase != 2) seq_bad++;
                phase = 3;
                fd_sel = s_display_sel;
            end
        end
        check("coincide_pixel_first", pix_ok, 1);
        check("coincide_clear_writes", nclr, 32);
        check("coincide_clear_done_pulses", ncd, 1);
        check("coincide_frame_done_pulses", nfd, 1);
        check("coincide_display_sel", fd_sel, 1);
        check("coincide_order_errors", seq_bad, 0);
        check("coincide_idle_after", s_busy, 0);

        // Switch to the full-size instance.
        @(negedge clk) begin rst_small = 1'b0; rst_big = 1'b1; end
        @(posedge clk); #1;
        check("ready_first_edge", ready, 1);

        for (int i = 0; i <= NVEC; i++) begin
            if (i < NVEC) begin
                x = vecs[i].vx; y = vecs[i].vy; color = vecs[i].vc; pixel_valid = 1'b1;
            end else begin
                pixel_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (i >= 1) begin
                check($sformatf("pix_we_%0d", i - 1), fb_we, vecs[i-1].we);
                if (vecs[i-1].we) begin
                    check($sformatf("pix_addr_%0d", i - 1), fb_addr, vecs[i-1].addr);
                    check($sformatf("pix_data_%0d", i - 1), fb_data, vecs[i-1].vc);
                end
            end
        end
        @(posedge clk); #1;
        check("clip_count", clip_count, 3);
        check("no_stray_write", fb_we, 0);

        // Full clear of buffer 1 (base 57600) with raster_done mid-clear, then the pending swap.
        clear_color = 8'h00; clear_start = 1'b1;
        @(posedge clk); #1;
        clear_start = 1'b0;
        nw = 0; bad = 0; cyc = 0; ncd = 0; nfd = 0; cd_cycle = 0; fd_cycle = 0;
        fd_seen = 1'b0; rd_sent = 1'b0; fd_sel = 1'b0;
        while (cyc < 60000 && !fd_seen) begin
            @(posedge clk); #1;
            cyc++;
            raster_done = 1'b0;
            if (fb_we) begin
                if (int'(fb_addr) != 57600 + nw || fb_data != 8'h00 || ready != 1'b0 || busy != 1'b1) bad++;
                nw++;
                if (nw == 100) begin x = 3; y = 3; color = 8'hFF; pixel_valid = 1'b1; end
                if (nw == 110) pixel_valid = 1'b0;
                if (nw == 30000 && !rd_sent) begin raster_done = 1'b1; rd_sent = 1'b1; end
            end
            if (clear_done) begin
                ncd++;
                cd_cycle = cyc;
                if (ready != 1'b1 || nw != 57600) bad++;
            end
            if (frame_done) begin
                nfd++;
                fd_cycle = cyc;
                fd_seen = 1'b1;
                fd_sel = display_sel;
            end
        end
        check("swap_within_budget", fd_seen, 1);
        check("clear_write_count", nw, 57600);
        check("clear_sequence_errors", bad, 0);
        check("clear_done_pulses", ncd, 1);
        check("clear_before_swap", (cd_cycle < fd_cycle), 1);
        check("swap_display_sel", fd_sel, 1);
        extra = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (frame_done || clear_done) extra++;
        end
        check("no_extra_pulses", extra, 0);
        check("idle_after_swap", ready, 1);

        // Buffer 1 is now displayed, so drawing targets base 0.
        x = 0; y = 0; color = 8'h77; pixel_valid = 1'b1;
        @(posedge clk); #1;
        pixel_valid = 1'b0;
        @(posedge clk); #1;
        check("origin_we", fb_we, 1);
        check("origin_addr", fb_addr, 0);
        check("origin_data", fb_data, 8'h77);

        // Reset in the middle of a clear, right after clear index 1000 appears.
        clear_color = 8'hEE; clear_start = 1'b1;
        @(posedge clk); #1;
        clear_start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 2000 && !hit; c++) begin
            @(posedge clk); #1;
            if (fb_we && fb_addr == 17'd1000) hit = 1'b1;
        end
        check("clear_idx_1000_reached", hit, 1);
        #2 rst_big = 1'b0;
        #1;
        check("midrst_fb_we", fb_we, 0);
        check("midrst_fb_addr", fb_addr, 0);
        check("midrst_fb_data", fb_data, 0);
        check("midrst_display_sel", display_sel, 0);
        check("midrst_ready", ready, 0);
        check("midrst_busy", busy, 0);
        check("midrst_pulses", {frame_done, clear_done}, 0);
        check("midrst_clip_count", clip_count, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_big = 1'b1;
        @(posedge clk); #1;
        check("ready_after_midrst", ready, 1);
        extra = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (clear_done || fb_we) extra++;
        end
        check("no_activity_after_midrst", extra, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/framebuffer_writer.md
FRAMEBUFFER_WRITER -- requirements
Module: framebuffer_writer

Interface
REQ-001 SHALL have parameters: H_RES, default 320, screen width in pixels; V_RES, default 180, screen height in pixels; COORD_WIDTH, default 32, signed coordinate width; COLOR_WIDTH, default 8, pixel data width.
REQ-002 SHALL derive localparams FB_SIZE = H_RES*V_RES and ADDR_WIDTH = $clog2(2*FB_SIZE), which is 17 at defaults.
REQ-003 SHALL have ports (name, direction, width, meaning):
- clk_in  input  1  sole clock
- rst_in  input  1  asynchronous, active-low reset
- x_in  input  COORD_WIDTH  signed pixel x from rasterizer
- y_in  input  COORD_WIDTH  signed pixel y from rasterizer
- pixel_valid  input  1  x_in/y_in valid this cycle (rasterizer drawing)
- color_in  input  COLOR_WIDTH  pixel colour, sampled with pixel_valid
- raster_done  input  1  one-cycle pulse, frame fully rasterized
- clear_start  input  1  one-cycle pulse, clear draw buffer
- clear_color  input  COLOR_WIDTH  fill value, sampled on clear_start
- ready  output  1  registered, high when pixels are accepted
- busy  output  1  high in any state other than IDLE
- fb_addr  output  ADDR_WIDTH  framebuffer BRAM write address
- fb_data  output  COLOR_WIDTH  framebuffer BRAM write data
- fb_we  output  1  framebuffer BRAM write enable
- display_sel  output  1  buffer shown by the display side (0 = lower half)
- frame_done  output  1  one-cycle pulse after a buffer swap
- clear_done  output  1  one-cycle pulse after a clear completes
- clip_count  output  16  count of rejected off-screen pixels, saturating

Function
REQ-004 SHALL write only to the draw buffer, which is the buffer not selected by display_sel; draw base = FB_SIZE when display_sel=0, and 0 when display_sel=1.
REQ-005 SHALL implement states IDLE, DRAIN, CLEAR, SWAP.
REQ-006 SHALL accept a pixel only when pixel_valid=1 and ready=1; pixel_valid while ready=0 SHALL be ignored with no write and no count.
REQ-007 SHALL drive ready=1 only in IDLE, registered, so the value reflects the current state.
REQ-008 SHALL use a 2-stage pixel pipeline.
- Stage 1: register x, y and colour; compute clip flag (x<0, x>=H_RES, y<0 or y>=V_RES) and y*H_RES.
- Stage 2: address = base + y*H_RES + x; fb_we=1 unless clipped.
- Latency: fb_we is asserted exactly 2 cycles after acceptance.
- Throughput: 1 pixel per cycle.
REQ-009 SHALL increment clip_count once in stage 2 for each clipped pixel, saturating at 16'hFFFF.
REQ-010 SHALL leave IDLE on clear_start and enter DRAIN.
REQ-011 SHALL make DRAIN wait until both pipeline stages are empty, then enter CLEAR.
REQ-012 SHALL make CLEAR write clear_color to draw base + i for i = 0..FB_SIZE-1, one address per cycle with fb_we=1.
REQ-013 SHALL, after the final clear write, pulse clear_done for 1 cycle and return to IDLE.
REQ-014 SHALL leave IDLE on raster_done (clear_start absent) and enter SWAP.
REQ-015 SHALL make SWAP wait for an empty pipeline, then toggle display_sel, pulse frame_done for 1 cycle, and return to IDLE.
REQ-016 SHALL, when raster_done and clear_start coincide in IDLE, service the clear first and latch raster_done as pending.
REQ-017 SHALL latch raster_done arriving in DRAIN or CLEAR as pending, and enter SWAP on the first IDLE cycle while pending, then clear the pending flag.
REQ-018 SHALL ignore clear_start arriving outside IDLE, with no latch.
REQ-019 SHALL accept a pixel that coincides with clear_start or raster_done in IDLE, and SHALL write it before the clear or swap begins.
REQ-020 SHALL drive fb_we=0 in every cycle not defined above, and SHALL never issue two writes in one cycle.

Reset
REQ-021 SHALL, on rst_in=0 at any time including mid-CLEAR, immediately force state=IDLE, both pipeline stages and the pending flag empty, fb_we=0, fb_addr=0, fb_data=0, display_sel=0, frame_done=0, clear_done=0, clip_count=0, busy=0 and ready=0.
REQ-022 SHALL set ready=1 on the first clock edge after rst_in deasserts.

Verification
REQ-023 SHALL cover pixel write: display_sel=0, pixel (5,2) colour 8'hA5 accepted -> 2 cycles later fb_we=1, fb_addr=57600+2*320+5=58245, fb_data=8'hA5.
REQ-024 SHALL cover clipping: pixels (-1,0), (320,0), (0,180) and (319,179) -> exactly one write, to 57600+57599=115199; clip_count=3.
REQ-025 SHALL cover clear: clear_start with clear_color=8'h00 -> FB_SIZE=57600 consecutive writes covering 57600..115199, ready=0 throughout, then one clear_done pulse and ready=1.
REQ-026 SHALL cover raster_done during CLEAR: raster_done pulse mid-clear -> clear completes, then SWAP, display_sel goes 0->1 and one frame_done pulse; the next pixel (0,0) writes address 0.
REQ-027 SHALL cover simultaneous events: pixel_valid, clear_start and raster_done in the same cycle -> pixel written first, then full clear, then swap, in that order.
REQ-028 SHALL cover reset mid-CLEAR: rst_in=0 at clear index 1000 -> fb_we=0 asynchronously, all outputs at reset values, no clear_done pulse.
